spatz_vcfg_ctrl: RTL and testbench
==================================

Name: spatz_vcfg_ctrl

Overview:
Vector configuration controller. Executes vsetvli/vsetivli/vsetvl requests from the issue stage and computes the new vl and vtype (legal SEW/LMUL, VLMAX, vill). It tracks outstanding vector operations and applies a new configuration only after they have all drained. It owns the architectural vl/vtype state that the VFUs and VLSU read.

Parameters:
VLEN, 512, vector register length in bits (power of two, >= 128)
ELEN, 32, maximum element width in bits
NrOutstanding, 8, maximum in-flight vector ops tracked; counter width is $clog2(NrOutstanding+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  config request valid
req_ready_o  out  1  config request accepted
req_avl_i  in  32  AVL (rs1 value or uimm)
req_vtype_i  in  8  zimm[7:0]: [7] vma, [6] vta, [5:3] vsew, [2:0] vlmul
req_vtype_rsv_i  in  1  upper vtype bits nonzero (forces vill)
req_rs1_x0_i  in  1  rs1 == x0 (vsetvl/vsetvli only; 0 for vsetivli)
req_rd_x0_i  in  1  rd == x0
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result consumed
rsp_vl_o  out  32  new vl, written to rd
issue_i  in  1  one vector op issued this cycle
retire_i  in  1  one vector op retired this cycle
cfg_busy_o  out  1  issue stage must not issue vector ops
outstanding_o  out  CW  current in-flight count
vl_o  out  32  architectural vl
vtype_o  out  9  architectural vtype (rvv_pkg::vtype_t)

Behaviour:
- Reset values: vtype_o = {vill=1, all other fields 0}; vl_o = 0; outstanding_o = 0; rsp_valid_o = 0; rsp_vl_o = 0; state IDLE. Reset mid-operation aborts the request with no response; state returns to the reset values.
- Counter: +1 on issue_i, -1 on retire_i. Simultaneous issue_i and retire_i leave it unchanged. Two violations are assertion failures, and the counter saturates in both cases:
  - issue_i when the count is NrOutstanding, or issue_i while cfg_busy_o = 1;
  - retire_i when the count is 0.
- FSM states IDLE, DRAIN, RESP:
  - IDLE: req_ready_o = 1. On a handshake, latch all request fields and go to DRAIN.
  - DRAIN: hold while outstanding_o != 0. When outstanding_o == 0, compute the result, update vl_o, vtype_o and rsp_vl_o on that edge, and go to RESP.
  - RESP: rsp_valid_o = 1, held stable until rsp_ready_i. Then go to IDLE.
- cfg_busy_o = 1 in DRAIN and RESP. req_ready_o = 0 outside IDLE.
- Minimum latency: handshake in cycle 0, update in cycle 1, rsp_valid_o in cycle 2.
- Legality (vill when any one holds):
  - vsew not in {EW_8, EW_16, EW_32};
  - vlmul = LMUL_RES;
  - fractional LMUL with SEW > ELEN*LMUL (LMUL_F8 always illegal; LMUL_F4 needs SEW=8; LMUL_F2 needs SEW<=16);
  - req_vtype_rsv_i = 1.
- On vill: vtype_o = {1, 0...}, vl_o = 0, rsp_vl_o = 0.
- VLMAX = (VLEN/SEW) shifted left by lmul for integer LMUL, or right by 1/2/3 for F2/F4/F8. Compute with shifts only, no divider.
- vl selection (legal vtype):
  - rs1_x0=1 and rd_x0=0: vl = VLMAX.
  - rs1_x0=1 and rd_x0=1: vl unchanged, if the old vtype was legal and the new VLMAX equals the old VLMAX. Otherwise set vill.
  - Otherwise: vl = min(AVL, VLMAX), using an unsigned 32-bit compare.
- vtype_o takes {0, vma, vta, vsew, vlmul} from the latched request.

Decomposition:
- Existing rvv_pkg: vew_e, vlmul_e and vtype_t already live there; reuse them.
- Add to spatz_pkg:
  - localparam VLEN;
  - a vcfg_req_t struct holding avl, vtype zimm, rsv, rs1_x0 and rd_x0;
  - the FSM state enum.
- One natural sub-module: spatz_vlmax, purely combinational, taking (vsew, vlmul) and producing {legal, vlmax}. It is reused by the decoder for VLMAX queries.

Test Plan:
- Reset (VLEN=512) -> vtype_o.vill=1, vl_o=0, outstanding_o=0, cfg_busy_o=0.
- SEW32 LMUL_1, AVL=20, rs1_x0=0 -> rsp_vl_o=16 at cycle 2, vtype_o=0x010. Then SEW8 LMUL_8, AVL=100 -> vl=100.
- SEW16 LMUL_2, rs1_x0=1, rd_x0=0 -> vl=64. Then SEW32 LMUL_4 with rs1_x0=rd_x0=1 (VLMAX 64 equal) -> vl stays 64. Then SEW8 LMUL_1 (VLMAX 64 equal) -> vl 64. Then SEW8 LMUL_2 (VLMAX 128) -> vill=1, vl=0.
- LMUL_F8 SEW8, or vsew=3'b011, or rsv=1 -> vill=1, rsp_vl_o=0.
- Issue 3 ops, then a request -> no rsp_valid_o and vl_o unchanged until the 3rd retire. Simultaneous issue+retire keeps the count. The update happens the cycle the count reaches 0.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_vl_o stable, req_ready_o=0. Assert rst_ni in DRAIN -> all outputs return to their reset values.

Source files
------------

// File: rtl/rvv_pkg.sv
// Shared RVV architectural types: element width, LMUL encoding and the vtype CSR layout.
`timescale 1ns/1ps
package rvv_pkg;

  typedef enum logic [2:0] {
    EW_8   = 3'b000,
    EW_16  = 3'b001,
    EW_32  = 3'b010,
    EW_64  = 3'b011,
    EW_128 = 3'b100,
    EW_256 = 3'b101,
    EW_512 = 3'b110,
    EW_RES = 3'b111
  } vew_e;

  typedef enum logic [2:0] {
    LMUL_1   = 3'b000,
    LMUL_2   = 3'b001,
    LMUL_4   = 3'b010,
    LMUL_8   = 3'b011,
    LMUL_RES = 3'b100,
    LMUL_F8  = 3'b101,
    LMUL_F4  = 3'b110,
    LMUL_F2  = 3'b111
  } vlmul_e;

  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } vtype_t;

endpackage

// File: rtl/spatz_pkg.sv
// Spatz configuration-controller types: latched request, FSM states and the vill reset value.
`timescale 1ns/1ps
package spatz_pkg;

  localparam int unsigned VLEN = 512;

  localparam rvv_pkg::vtype_t VTYPE_VILL = rvv_pkg::vtype_t'(9'h100);

  typedef struct packed {
    logic [31:0] avl;
    logic [7:0]  vtype;
    logic        rsv;
    logic        rs1_x0;
    logic        rd_x0;
  } vcfg_req_t;

  typedef enum logic [1:0] {
    VCFG_IDLE  = 2'd0,
    VCFG_DRAIN = 2'd1,
    VCFG_RESP  = 2'd2
  } vcfg_state_e;

endpackage

// File: rtl/spatz_vcfg_ctrl_if.sv
// Request/response channel between the issue stage (master) and the config controller (slave).
`timescale 1ns/1ps
interface spatz_vcfg_ctrl_if;

  // Both channels use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; once raised, valid and its payload stay stable until that edge.
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_avl_i;
  logic [7:0]  req_vtype_i;
  logic        req_vtype_rsv_i;
  logic        req_rs1_x0_i;
  logic        req_rd_x0_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_vl_o;

  modport master (
    output req_valid_i, req_avl_i, req_vtype_i, req_vtype_rsv_i, req_rs1_x0_i, req_rd_x0_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_vl_o
  );

  modport slave (
    input  req_valid_i, req_avl_i, req_vtype_i, req_vtype_rsv_i, req_rs1_x0_i, req_rd_x0_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_vl_o
  );

endinterface

// File: rtl/spatz_vlmax.sv
// Combinational vtype legality check and VLMAX computation (shifts only, no divider).
`timescale 1ns/1ps
module spatz_vlmax
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN = 512,
  parameter int unsigned ELEN = 32
) (
  input  vew_e        vsew_i,
  input  vlmul_e      vlmul_i,
  output logic        legal_o,
  output logic [31:0] vlmax_o
);

  localparam logic [31:0] VlenW = 32'(VLEN);
  localparam logic [31:0] ElenW = 32'(ELEN);

  logic [4:0]  base_sh;
  logic [31:0] sew_bits;
  logic [31:0] base;
  logic [1:0]  frac_sh;

  always_comb begin
    base_sh  = 5'd3 + {2'b00, vsew_i};
    sew_bits = 32'd8 << vsew_i;
    base     = VlenW >> base_sh;
    // F2/F4/F8 encode as 111/110/101, so 4 - low bits gives the right shift 1/2/3.
    frac_sh  = 2'(3'd4 - {1'b0, vlmul_i[1:0]});
    legal_o  = 1'b1;
    vlmax_o  = '0;

    unique case (vsew_i)
      EW_8, EW_16, EW_32: ;
      default: legal_o = 1'b0;
    endcase

    unique case (vlmul_i)
      LMUL_1, LMUL_2, LMUL_4, LMUL_8: vlmax_o = base << vlmul_i[1:0];
      LMUL_F2, LMUL_F4, LMUL_F8: begin
        vlmax_o = base >> frac_sh;
        if ((sew_bits << frac_sh) > ElenW) legal_o = 1'b0;
      end
      default: legal_o = 1'b0;
    endcase

    if (!legal_o) vlmax_o = '0;
  end

endmodule

// File: rtl/spatz_vcfg_ctrl.sv
// Vector configuration controller: executes vset{i}vl{i}, waits for in-flight ops to drain,
// then commits the architectural vl/vtype and returns the new vl.
`timescale 1ns/1ps
module spatz_vcfg_ctrl
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN          = spatz_pkg::VLEN,
  parameter int unsigned ELEN          = 32,
  parameter int unsigned NrOutstanding = 8,
  localparam int unsigned CW           = $clog2(NrOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  spatz_vcfg_ctrl_if.slave       cfg_if,
  input  logic                   issue_i,
  input  logic                   retire_i,
  output logic                   cfg_busy_o,
  output logic [CW-1:0]          outstanding_o,
  output logic [31:0]            vl_o,
  output vtype_t                 vtype_o,
  output spatz_pkg::vcfg_state_e state_o
);

  import spatz_pkg::*;

  localparam logic [CW-1:0] CntMax = CW'(NrOutstanding);

  vcfg_state_e state_q, state_d;
  vcfg_req_t   req_q, req_d;
  vtype_t      vtype_q, vtype_d;
  logic [31:0] vl_q, vl_d;
  logic [31:0] rsp_vl_q, rsp_vl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        new_legal_raw, old_legal_raw;
  logic [31:0] vlmax_new, vlmax_old;
  logic        res_vill;
  logic [31:0] res_vl;

  spatz_vlmax #(.VLEN(VLEN), .ELEN(ELEN)) i_vlmax_new (
    .vsew_i  (vew_e'(req_q.vtype[5:3])),
    .vlmul_i (vlmul_e'(req_q.vtype[2:0])),
    .legal_o (new_legal_raw),
    .vlmax_o (vlmax_new)
  );

  spatz_vlmax #(.VLEN(VLEN), .ELEN(ELEN)) i_vlmax_old (
    .vsew_i  (vtype_q.vsew),
    .vlmul_i (vtype_q.vlmul),
    .legal_o (old_legal_raw),
    .vlmax_o (vlmax_old)
  );

  // In-flight counter; saturates on protocol violations (flagged by the assertions below).
  always_comb begin
    cnt_d = cnt_q;
    if (issue_i && !retire_i && cnt_q != CntMax) cnt_d = cnt_q + CW'(1);
    else if (retire_i && !issue_i && cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    res_vill = 1'b0;
    res_vl   = '0;
    if (!new_legal_raw || req_q.rsv) begin
      res_vill = 1'b1;
    end else if (req_q.rs1_x0 && !req_q.rd_x0) begin
      res_vl = vlmax_new;
    end else if (req_q.rs1_x0) begin
      // Keep-vl form is only legal when the ratio SEW/LMUL (hence VLMAX) is unchanged.
      if (!vtype_q.vill && old_legal_raw && vlmax_new == vlmax_old) res_vl = vl_q;
      else res_vill = 1'b1;
    end else begin
      res_vl = (req_q.avl < vlmax_new) ? req_q.avl : vlmax_new;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vtype_d  = vtype_q;
    vl_d     = vl_q;
    rsp_vl_d = rsp_vl_q;
    unique case (state_q)
      VCFG_IDLE: begin
        if (cfg_if.req_valid_i) begin
          req_d = '{avl:    cfg_if.req_avl_i,
                    vtype:  cfg_if.req_vtype_i,
                    rsv:    cfg_if.req_vtype_rsv_i,
                    rs1_x0: cfg_if.req_rs1_x0_i,
                    rd_x0:  cfg_if.req_rd_x0_i};
          state_d = VCFG_DRAIN;
        end
      end
      VCFG_DRAIN: begin
        if (cnt_q == '0) begin
          if (res_vill) begin
            vtype_d  = VTYPE_VILL;
            vl_d     = '0;
            rsp_vl_d = '0;
          end else begin
            vtype_d  = vtype_t'({1'b0, req_q.vtype});
            vl_d     = res_vl;
            rsp_vl_d = res_vl;
          end
          state_d = VCFG_RESP;
        end
      end
      VCFG_RESP: begin
        if (cfg_if.rsp_ready_i) state_d = VCFG_IDLE;
      end
      default: state_d = VCFG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= VCFG_IDLE;
      req_q    <= '0;
      vtype_q  <= VTYPE_VILL;
      vl_q     <= '0;
      rsp_vl_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      vtype_q  <= vtype_d;
      vl_q     <= vl_d;
      rsp_vl_q <= rsp_vl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cfg_if.req_ready_o = (state_q == VCFG_IDLE);
  assign cfg_if.rsp_valid_o = (state_q == VCFG_RESP);
  assign cfg_if.rsp_vl_o    = rsp_vl_q;
  assign cfg_busy_o         = (state_q != VCFG_IDLE);
  assign outstanding_o      = cnt_q;
  assign vl_o               = vl_q;
  assign vtype_o            = vtype_q;
  assign state_o            = state_q;

  a_issue_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_i && (cfg_busy_o || (cnt_q == CntMax && !retire_i))))
    else $error("vector op issued while busy or counter full");

  a_retire_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire_i && !issue_i && cnt_q == '0))
    else $error("vector op retired with nothing outstanding");

endmodule

// File: tb/tb_spatz_vcfg_ctrl.sv
// Directed bench for spatz_vcfg_ctrl: request driver plus a response monitor fed by expected queues.
`timescale 1ns/1ps
module tb_spatz_vcfg_ctrl;
  import rvv_pkg::*;
  import spatz_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic issue_i = 1'b0;
  logic retire_i = 1'b0;
  logic cfg_busy_o;
  logic [CW-1:0] outstanding_o;
  logic [31:0] vl_o;
  vtype_t vtype_o;
  vcfg_state_e state_o;

  spatz_vcfg_ctrl_if cfg_if();

  spatz_vcfg_ctrl #(.VLEN(512), .ELEN(32), .NrOutstanding(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cfg_if        (cfg_if),
    .issue_i       (issue_i),
    .retire_i      (retire_i),
    .cfg_busy_o    (cfg_busy_o),
    .outstanding_o (outstanding_o),
    .vl_o          (vl_o),
    .vtype_o       (vtype_o),
    .state_o       (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [8:0]  exp_vt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_ni && cfg_if.rsp_valid_o && cfg_if.rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [31:0] ev;
        logic [8:0]  et;
        ev = exp_q.pop_front();
        et = exp_vt_q.pop_front();
        check("rsp_vl", cfg_if.rsp_vl_o, ev);
        check("vl_o", vl_o, ev);
        check("vtype_o", {23'd0, vtype_o}, {23'd0, et});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] avl, input logic [7:0] vt, input logic rsv,
                          input logic r1x0, input logic rdx0, input logic push,
                          input logic [31:0] exp_vl, input logic [8:0] exp_vt);
    int n;
    if (push) begin
      exp_q.push_back(exp_vl);
      exp_vt_q.push_back(exp_vt);
    end
    cfg_if.req_valid_i     = 1'b1;
    cfg_if.req_avl_i       = avl;
    cfg_if.req_vtype_i     = vt;
    cfg_if.req_vtype_rsv_i = rsv;
    cfg_if.req_rs1_x0_i    = r1x0;
    cfg_if.req_rd_x0_i     = rdx0;
    n = 0;
    @(negedge clk);
    while (!cfg_if.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cfg_if.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cfg_if.req_ready_o && exp_q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vtype"},     {23'd0, vtype_o}, 32'h100);
    check({tag, "_vl"},        vl_o, 32'd0);
    check({tag, "_outst"},     {28'd0, outstanding_o}, 32'd0);
    check({tag, "_busy"},      {31'd0, cfg_busy_o}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, cfg_if.rsp_valid_o}, 32'd0);
    check({tag, "_rsp_vl"},    cfg_if.rsp_vl_o, 32'd0);
    check({tag, "_req_ready"}, {31'd0, cfg_if.req_ready_o}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cfg_if.req_valid_i     = 1'b0;
    cfg_if.req_avl_i       = '0;
    cfg_if.req_vtype_i     = '0;
    cfg_if.req_vtype_rsv_i = 1'b0;
    cfg_if.req_rs1_x0_i    = 1'b0;
    cfg_if.req_rd_x0_i     = 1'b0;
    cfg_if.rsp_ready_i     = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    step();

    // SEW32 LMUL1, AVL 20 -> VLMAX 16; response must appear exactly in cycle 2
    send_req(32'd20, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16, 9'h010);
    @(negedge clk);
    check("lat_cycle1_no_rsp", {31'd0, cfg_if.rsp_valid_o}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_rsp", {31'd0, cfg_if.rsp_valid_o}, 32'd1);
    wait_idle();

    // SEW8 LMUL8: VLMAX 512
    send_req(32'd100, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 32'd100, 9'h003);
    // SEW16 LMUL2, rs1=x0 rd!=x0 -> VLMAX 64
    send_req(32'd5, 8'h09, 1'b0, 1'b1, 1'b0, 1'b1, 32'd64, 9'h009);
    // SEW32 LMUL4 keep-vl, VLMAX 64 unchanged
    send_req(32'd5, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 32'd64, 9'h012);
    // SEW8 LMUL1 keep-vl, VLMAX 64 unchanged
    send_req(32'd5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'd64, 9'h000);
    // SEW8 LMUL2 keep-vl, VLMAX 128 differs -> vill
    send_req(32'd5, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 9'h100);
    // keep-vl after vill -> vill
    send_req(32'd5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 9'h100);
    // LMUL_F8 SEW8 -> vill
    send_req(32'd10, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 9'h100);
    // vsew = 3'b011 (SEW64 > ELEN) -> vill
    send_req(32'd10, 8'h18, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 9'h100);
    // reserved upper bits -> vill
    send_req(32'd10, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 9'h100);
    // vma/vta set, SEW16 F2 legal, VLMAX 16
    send_req(32'd5, 8'hCF, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 9'h0CF);
    // SEW16 F4 -> vill
    send_req(32'd5, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 9'h100);
    // SEW8 F4, VLMAX 16
    send_req(32'd100, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16, 9'h006);
    // AVL boundaries against VLMAX 16 (SEW32 LMUL1)
    send_req(32'd0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 9'h010);
    send_req(32'd16, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16, 9'h010);
    send_req(32'hFFFF_FFFF, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16, 9'h010);
    wait_idle();

    // drain: 3 ops in flight, request waits for the third retire
    issue_i = 1'b1;
    repeat (3) step();
    issue_i = 1'b0;
    @(negedge clk);
    check("outst_3", {28'd0, outstanding_o}, 32'd3);
    step();
    issue_i = 1'b1;
    retire_i = 1'b1;
    step();
    issue_i = 1'b0;
    retire_i = 1'b0;
    @(negedge clk);
    check("outst_issue_retire", {28'd0, outstanding_o}, 32'd3);
    step();
    send_req(32'd7, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 9'h010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drain_no_rsp", {31'd0, cfg_if.rsp_valid_o}, 32'd0);
      check("drain_vl_hold", vl_o, 32'd16);
      check("drain_busy", {31'd0, cfg_busy_o}, 32'd1);
    end
    step();
    retire_i = 1'b1;
    repeat (2) step();
    retire_i = 1'b0;
    @(negedge clk);
    check("drain_outst_1", {28'd0, outstanding_o}, 32'd1);
    check("drain_outst1_no_rsp", {31'd0, cfg_if.rsp_valid_o}, 32'd0);
    step();
    retire_i = 1'b1;
    step();
    retire_i = 1'b0;
    @(negedge clk);
    check("drain_outst_0", {28'd0, outstanding_o}, 32'd0);
    check("drain_update_cycle_no_rsp", {31'd0, cfg_if.rsp_valid_o}, 32'd0);
    check("drain_update_cycle_vl_old", vl_o, 32'd16);
    @(negedge clk);
    check("drain_rsp_next", {31'd0, cfg_if.rsp_valid_o}, 32'd1);
    check("drain_vl_new", vl_o, 32'd7);
    wait_idle();

    // response back-pressure: SEW8 LMUL2, VLMAX 128
    cfg_if.rsp_ready_i = 1'b0;
    send_req(32'd200, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 32'd128, 9'h001);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'd0, cfg_if.rsp_valid_o}, 32'd1);
      check("stall_rsp_vl", cfg_if.rsp_vl_o, 32'd128);
      check("stall_req_ready", {31'd0, cfg_if.req_ready_o}, 32'd0);
    end
    step();
    cfg_if.rsp_ready_i = 1'b1;
    wait_idle();

    // reset while draining aborts the request without a response
    issue_i = 1'b1;
    step();
    issue_i = 1'b0;
    send_req(32'd9, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 9'h000);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, cfg_busy_o}, 32'd1);
    check("pre_rst_outst", {28'd0, outstanding_o}, 32'd1);
    step();
    rst_ni = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    step();
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");
    step();

    send_req(32'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 9'h000);
    wait_idle();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
